// File: rtl/score_pkg.sv
// score_pkg: shared state encoding, display selects and score defaults
package score_pkg;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PLAY   = 3'd1,
        RANK   = 3'd2,
        INSERT = 3'd3,
        HOLD   = 3'd4
    } state_t;
    localparam logic [1:0] SEL_CUR    = 2'd0;
    localparam logic [1:0] SEL_FIRST  = 2'd1;
    localparam logic [1:0] SEL_SECOND = 2'd2;
    localparam logic [1:0] SEL_THIRD  = 2'd3;
    localparam int SCORE_W_DEF   = 11;
    localparam int SCORE_MAX_DEF = 999;
endpackage

// File: rtl/score_controller_rank_table.sv
// rank_table: sorted three-entry high-score table with rank latch and insert
module rank_table
    import score_pkg::*;
#(
    parameter int SCORE_W = SCORE_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_rank_en,
    input  logic               i_insert_en,
    input  logic [SCORE_W-1:0] i_score,
    output logic [SCORE_W-1:0] o_first,
    output logic [SCORE_W-1:0] o_second,
    output logic [SCORE_W-1:0] o_third
);
    logic [SCORE_W-1:0] r_first, r_second, r_third;
    logic [1:0]         r_rank;
    logic [1:0]         w_rank;
    // strict compares keep an existing entry ahead of an equal new score
    assign w_rank = (i_score > r_first)  ? 2'd0 :
                    (i_score > r_second) ? 2'd1 :
                    (i_score > r_third)  ? 2'd2 : 2'd3;
    // rank is latched one cycle before the shift-down insert uses it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rank   <= 2'd3;
            r_first  <= '0;
            r_second <= '0;
            r_third  <= '0;
        end else begin
            if (i_rank_en)
                r_rank <= w_rank;
            if (i_insert_en) begin
                if (r_rank == 2'd0)
                    r_first <= i_score;
                if (r_rank <= 2'd1)
                    r_second <= (r_rank == 2'd0) ? r_first : i_score;
                if (r_rank <= 2'd2)
                    r_third <= (r_rank == 2'd2) ? i_score : r_second;
            end
        end
    end
    assign o_first  = r_first;
    assign o_second = r_second;
    assign o_third  = r_third;
endmodule

// File: rtl/score_controller.sv
// score_controller: session score, high-score commit and display rotation
module score_controller
    import score_pkg::*;
#(
    parameter int SCORE_W       = SCORE_W_DEF,
    parameter int SCORE_MAX     = SCORE_MAX_DEF,
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int ROTATE_CYCLES = 100_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               eat,
    input  logic               is_dead,
    output logic [2:0]         state,
    output logic               busy,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] first,
    output logic [SCORE_W-1:0] second,
    output logic [SCORE_W-1:0] third,
    output logic [1:0]         disp_sel,
    output logic [SCORE_W-1:0] disp_val,
    output logic [3:0]         dig0,
    output logic [3:0]         dig1,
    output logic [3:0]         dig2
);
    state_t             r_state, w_next;
    logic [SCORE_W-1:0] r_score, w_score_nxt;
    logic [1:0]         r_disp_sel, w_sel_nxt;
    logic [31:0]        r_cnt, w_cnt_nxt;
    logic               r_eat_q;
    logic               w_eat_edge, w_hold_done, w_rot_done;
    assign w_eat_edge  = eat & ~r_eat_q;
    assign w_hold_done = (r_cnt == 32'(HOLD_CYCLES - 1));
    assign w_rot_done  = (r_cnt == 32'(ROTATE_CYCLES - 1));
    // state, score, display select, shared counter and eat edge history
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_score    <= '0;
            r_disp_sel <= SEL_CUR;
            r_cnt      <= '0;
            r_eat_q    <= 1'b1;
        end else begin
            r_state    <= w_next;
            r_score    <= w_score_nxt;
            r_disp_sel <= w_sel_nxt;
            r_cnt      <= w_cnt_nxt;
            r_eat_q    <= eat;
        end
    end
    // next-state logic; the counter clears on every state change
    always_comb begin
        w_next      = r_state;
        w_score_nxt = r_score;
        w_sel_nxt   = SEL_CUR;
        w_cnt_nxt   = '0;
        case (r_state)
            IDLE: begin
                w_next      = start ? PLAY : IDLE;
                w_score_nxt = start ? '0 : r_score;
                w_cnt_nxt   = (start || w_rot_done) ? '0 : r_cnt + 32'd1;
                w_sel_nxt   = start ? SEL_CUR : (w_rot_done ? r_disp_sel + 2'd1 : r_disp_sel);
            end
            PLAY: begin
                w_next      = is_dead ? RANK : PLAY;
                w_score_nxt = (!is_dead && w_eat_edge && r_score != SCORE_W'(SCORE_MAX)) ? r_score + 1'b1 : r_score;
            end
            RANK:   w_next = INSERT;
            INSERT: w_next = HOLD;
            HOLD: begin
                w_next    = w_hold_done ? IDLE : HOLD;
                w_cnt_nxt = w_hold_done ? '0 : r_cnt + 32'd1;
            end
            default: w_next = IDLE;
        endcase
    end
    rank_table #(.SCORE_W(SCORE_W)) u_rank_table (
        .clk        (clk),
        .rst        (rst),
        .i_rank_en  (r_state == RANK),
        .i_insert_en(r_state == INSERT),
        .i_score    (r_score),
        .o_first    (first),
        .o_second   (second),
        .o_third    (third)
    );
    // display mux over registered values
    always_comb begin
        disp_val = (r_disp_sel == SEL_FIRST)  ? first  :
                   (r_disp_sel == SEL_SECOND) ? second :
                   (r_disp_sel == SEL_THIRD)  ? third  : r_score;
    end
    assign dig0     = 4'(disp_val % SCORE_W'(10));
    assign dig1     = 4'((disp_val / SCORE_W'(10)) % SCORE_W'(10));
    assign dig2     = 4'((disp_val / SCORE_W'(100)) % SCORE_W'(10));
    assign state    = r_state;
    assign busy     = (r_state == RANK) || (r_state == INSERT) || (r_state == HOLD);
    assign score    = r_score;
    assign disp_sel = r_disp_sel;
endmodule

// File: tb/tb_score_controller.sv
// tb_score_controller: directed checks of scoring, commit, ranking and rotation
module tb_score_controller;
    import score_pkg::*;
    localparam int W = 11;
    logic         clk = 1'b0;
    logic         rst, start, eat, is_dead;
    logic [2:0]   state;
    logic         busy;
    logic [W-1:0] score, first, second, third, disp_val;
    logic [1:0]   disp_sel;
    logic [3:0]   dig0, dig1, dig2;
    int           n_chk = 0;
    int           n_pass = 0;
    int           vals[4];
    int           exp_sel;

    score_controller #(
        .SCORE_W(W), .SCORE_MAX(999), .HOLD_CYCLES(4), .ROTATE_CYCLES(3)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .eat(eat), .is_dead(is_dead),
        .state(state), .busy(busy), .score(score),
        .first(first), .second(second), .third(third),
        .disp_sel(disp_sel), .disp_val(disp_val),
        .dig0(dig0), .dig1(dig1), .dig2(dig2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_eat(input int n);
        repeat (n) begin
            eat = 1'b1; tick();
            eat = 1'b0; tick();
        end
    endtask

    task automatic play(input int n);
        start = 1'b1; tick();
        start = 1'b0;
        pulse_eat(n);
    endtask

    task automatic commit(input string tag, input logic with_eat);
        int cyc = 0;
        eat = with_eat; is_dead = 1'b1; tick();
        eat = 1'b0; is_dead = 1'b0;
        while (busy && cyc < 20) begin
            cyc++;
            if (state == HOLD) check({tag, "_hold_sel"}, int'(disp_sel), 0);
            tick();
        end
        check({tag, "_busy_len"}, cyc, 6);
        check({tag, "_idle"}, int'(state), int'(IDLE));
        check({tag, "_idle_sel"}, int'(disp_sel), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; eat = 1'b1; start = 1'b0; is_dead = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        check("rst_state", int'(state), int'(IDLE));
        check("rst_score", int'(score), 0);
        check("rst_first", int'(first), 0);
        check("rst_second", int'(second), 0);
        check("rst_third", int'(third), 0);
        check("rst_sel", int'(disp_sel), 0);
        start = 1'b1; tick();
        start = 1'b0; tick();
        check("eat_held_state", int'(state), int'(PLAY));
        check("eat_held_score", int'(score), 0);
        eat = 1'b0; tick();
        pulse_eat(3);
        start = 1'b1; tick();
        start = 1'b0;
        pulse_eat(2);
        check("s5_score", int'(score), 5);
        commit("s5", 1'b0);
        check("s5_first", int'(first), 5);
        check("s5_second", int'(second), 0);
        rst = 1'b1; tick();
        rst = 1'b0;
        play(7); commit("a7", 1'b0);
        play(3); commit("b3", 1'b0);
        play(7); commit("c7", 1'b0);
        check("tie_first", int'(first), 7);
        check("tie_second", int'(second), 7);
        check("tie_third", int'(third), 3);
        play(4);
        commit("dead_eat", 1'b1);
        check("dead_eat_score", int'(score), 4);
        check("dead_eat_third", int'(third), 4);
        check("dead_eat_second", int'(second), 7);
        play(1002);
        check("sat_score", int'(score), 999);
        check("sat_disp", int'(disp_val), 999);
        check("sat_dig2", int'(dig2), 9);
        check("sat_dig1", int'(dig1), 9);
        check("sat_dig0", int'(dig0), 9);
        commit("sat", 1'b0);
        check("sat_first", int'(first), 999);
        check("sat_second", int'(second), 7);
        check("sat_third", int'(third), 7);
        play(8);
        is_dead = 1'b1; tick();
        is_dead = 1'b0;
        check("mid_rank", int'(state), int'(RANK));
        tick();
        check("mid_insert", int'(state), int'(INSERT));
        rst = 1'b1; tick();
        rst = 1'b0;
        check("mid_rst_state", int'(state), int'(IDLE));
        check("mid_rst_first", int'(first), 0);
        check("mid_rst_second", int'(second), 0);
        check("mid_rst_third", int'(third), 0);
        play(20);  commit("r20", 1'b0);
        play(345); commit("r345", 1'b0);
        play(6);   commit("r6", 1'b0);
        play(3);   commit("r3", 1'b0);
        check("rot_first", int'(first), 345);
        check("rot_second", int'(second), 20);
        check("rot_third", int'(third), 6);
        vals = '{3, 345, 20, 6};
        for (int i = 1; i <= 12; i++) begin
            tick();
            exp_sel = (i / 3) % 4;
            check($sformatf("rot_sel_%0d", i), int'(disp_sel), exp_sel);
            check($sformatf("rot_val_%0d", i), int'(disp_val), vals[exp_sel]);
            check($sformatf("rot_dig0_%0d", i), int'(dig0), vals[exp_sel] % 10);
            check($sformatf("rot_dig1_%0d", i), int'(dig1), (vals[exp_sel] / 10) % 10);
            check($sformatf("rot_dig2_%0d", i), int'(dig2), vals[exp_sel] / 100);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
